// File: rtl/ripple_adder_unit_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands and observes the registered result.
interface ripple_adder_unit_if #(
  parameter int W = 5
);
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, out_valid
  );
endinterface

// File: rtl/ripple_adder_unit.sv
// Registered W-bit structural ripple-carry adder (FP16 exponent datapath).
// One register stage; the result is held while in_valid is low.

module half_adder_cell (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

// Two half adders give s = x^y^ci and co = (x&y) | (ci & (x^y)).
module full_adder_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  logic p, g, t;

  half_adder_cell u_ha0 (.x_i(x_i), .y_i(y_i),  .s_o(p),   .c_o(g));
  half_adder_cell u_ha1 (.x_i(p),   .y_i(ci_i), .s_o(s_o), .c_o(t));

  assign co_o = g | t;
endmodule

module ripple_adder_unit #(
  parameter int W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ripple_adder_unit_if.slave    bus
);
  logic [W-1:0] s_w;
  logic [W:0]   c_w;

  logic [W-1:0] sum_q,  sum_d;
  logic         cout_q, cout_d;
  logic         vld_q,  vld_d;

  assign c_w[0] = bus.cin;

  // Each bit waits on the carry of the bit below: W carry stages end to end.
  for (genvar g = 0; g < W; g++) begin : g_bit
    full_adder_cell u_fa (
      .x_i (bus.a[g]),
      .y_i (bus.b[g]),
      .ci_i(c_w[g]),
      .s_o (s_w[g]),
      .co_o(c_w[g+1])
    );
  end

  // Operands are ignored when not valid, so X on idle inputs never reaches state.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    vld_d  = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = s_w;
      cout_d = c_w[W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_ripple_adder_unit.sv
// Scoreboard bench for ripple_adder_unit at W=5 (directed + exhaustive) and W=8 (random).
module tb_ripple_adder_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ripple_adder_unit_if #(.W(5)) b5 ();
  ripple_adder_unit_if #(.W(8)) b8 ();

  ripple_adder_unit #(.W(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
  ripple_adder_unit #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  logic [5:0] q5[$];
  logic [8:0] q8[$];
  int checks = 0;
  int errors = 0;

  task automatic idle();
    b5.in_valid = 1'b0; b5.a = '0; b5.b = '0; b5.cin = 1'b0;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive5(input logic [4:0] a, input logic [4:0] b, input logic c);
    b5.in_valid = 1'b1; b5.a = a; b5.b = b; b5.cin = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b5.in_valid = 1'($urandom); b5.a = 5'($urandom); b5.b = 5'($urandom); b5.cin = 1'($urandom);
      b8.in_valid = 1'($urandom); b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom);
      #4;
      checks++;
      if ({b5.out_valid, b5.cout, b5.sum} !== 7'd0 || {b8.out_valid, b8.cout, b8.sum} !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold: w5 {v,c,s}=%b w8 {v,c,s}=%b, required all zero",
                 {b5.out_valid, b5.cout, b5.sum}, {b8.out_valid, b8.cout, b8.sum});
      end
    end
    idle();
    @(negedge clk) rst_n = 1'b1;
    // Mid-stream reset: capture 3+4, launch 1+1, then reset asynchronously before its edge.
    step(); drive5(5'd3, 5'd4, 1'b0);
    step(); drive5(5'd1, 5'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({b5.out_valid, b5.cout, b5.sum} !== 7'd0) begin
      errors++;
      $display("FAIL reset_async: {v,c,s}=%b, required 0", {b5.out_valid, b5.cout, b5.sum});
    end
    idle();
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++;
    if ({b5.out_valid, b5.cout, b5.sum} !== 7'd0) begin
      errors++;
      $display("FAIL reset_discard: {v,c,s}=%b, required 0", {b5.out_valid, b5.cout, b5.sum});
    end
  endtask

  task automatic test_bias_add();
    drive5(5'b01111, 5'b00001, 1'b0); q5.push_back({1'b0, 5'b10000});
    step(); idle();
    begin
      logic [5:0] e = q5.pop_front();
      checks++;
      if (b5.out_valid !== 1'b1 || {b5.cout, b5.sum} !== e) begin
        errors++;
        $display("FAIL bias_add: v=%b {c,s}=%b, required v=1 {c,s}=%b", b5.out_valid, {b5.cout, b5.sum}, e);
      end
    end
  endtask

  task automatic test_wrap();
    drive5(5'b11111, 5'b00001, 1'b0); q5.push_back({1'b1, 5'b00000});
    step();
    for (int i = 0; i < 2; i++) begin
      logic [5:0] e;
      if (i == 0) begin drive5(5'b11111, 5'b11111, 1'b1); q5.push_back({1'b1, 5'b11111}); end
      else idle();
      e = q5.pop_front();
      checks++;
      if (b5.out_valid !== 1'b1 || {b5.cout, b5.sum} !== e) begin
        errors++;
        $display("FAIL wrap_%0d: v=%b {c,s}=%b, required v=1 {c,s}=%b", i, b5.out_valid, {b5.cout, b5.sum}, e);
      end
      if (i == 0) step();
    end
  endtask

  task automatic test_subtract();
    drive5(5'b10100, ~5'b01111, 1'b1); q5.push_back({1'b1, 5'b00101});
    step(); idle();
    begin
      logic [5:0] e = q5.pop_front();
      checks++;
      if (b5.out_valid !== 1'b1 || {b5.cout, b5.sum} !== e) begin
        errors++;
        $display("FAIL subtract: v=%b {c,s}=%b, required v=1 {c,s}=%b", b5.out_valid, {b5.cout, b5.sum}, e);
      end
    end
  endtask

  task automatic test_hold();
    drive5(5'd3, 5'd4, 1'b0); q5.push_back(6'd7);
    step();
    begin
      logic [5:0] e = q5.pop_front();
      checks++;
      if (b5.out_valid !== 1'b1 || {b5.cout, b5.sum} !== e) begin
        errors++;
        $display("FAIL hold_capture: v=%b {c,s}=%b, required v=1 {c,s}=%b", b5.out_valid, {b5.cout, b5.sum}, e);
      end
      b5.in_valid = 1'b0; b5.a = 5'bxxxxx; b5.b = 5'd9; b5.cin = 1'bx;
      for (int i = 0; i < 2; i++) begin
        step();
        checks++;
        if (b5.out_valid !== 1'b0 || {b5.cout, b5.sum} !== e) begin
          errors++;
          $display("FAIL hold_%0d: v=%b {c,s}=%b, required v=0 {c,s}=%b", i, b5.out_valid, {b5.cout, b5.sum}, e);
        end
      end
    end
    idle();
  endtask

  task automatic test_back_to_back_w5();
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] v = 11'(i);
      logic [5:0] e;
      drive5(v[9:5], v[4:0], v[10]);
      q5.push_back(6'(v[9:5]) + 6'(v[4:0]) + 6'(v[10]));
      step();
      if (q5.size() == 0) begin
        errors++; $display("FAIL sweep5_queue: empty at %0d", i); continue;
      end
      e = q5.pop_front();
      checks++;
      if (b5.out_valid !== 1'b1 || {b5.cout, b5.sum} !== e) begin
        errors++;
        $display("FAIL sweep5[%0d]: v=%b {c,s}=%b, required v=1 {c,s}=%b", i, b5.out_valid, {b5.cout, b5.sum}, e);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back_w8();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a = 8'($urandom);
      logic [7:0] b = 8'($urandom);
      logic       c = 1'($urandom);
      logic [8:0] e;
      if (i == 0) begin a = 8'hFF; b = 8'hFF; c = 1'b1; end
      b8.in_valid = 1'b1; b8.a = a; b8.b = b; b8.cin = c;
      q8.push_back(9'(a) + 9'(b) + 9'(c));
      step();
      if (q8.size() == 0) begin
        errors++; $display("FAIL sweep8_queue: empty at %0d", i); continue;
      end
      e = q8.pop_front();
      checks++;
      if (b8.out_valid !== 1'b1 || {b8.cout, b8.sum} !== e) begin
        errors++;
        $display("FAIL sweep8[%0d]: v=%b {c,s}=%b, required v=1 {c,s}=%b", i, b8.out_valid, {b8.cout, b8.sum}, e);
      end
    end
    idle();
    step();
    checks++;
    if (b8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep8_drain: out_valid=%b, required 0", b8.out_valid);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_bias_add();
    test_wrap();
    test_subtract();
    test_hold();
    test_back_to_back_w5();
    test_back_to_back_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_adder_unit.md
# ripple_adder_unit

Registered W-bit ripple-carry adder built from explicit half-adder and full-adder cells. It is the exponent datapath adder of the FP16 multiplier: it computes `(a_exp − bias) + b_exp` and also `exp + 1` for post-normalisation. One pipeline register stage makes the block clocked and resettable. Default width is 5 bits, the FP16 exponent field.

## Interface
- `W`, default 5: operand and sum width in bits; legal range 2..32.
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: qualifies `a`, `b` and `cin` this cycle.
- `a`, in, W: operand A, unsigned.
- `b`, in, W: operand B, unsigned.
- `cin`, in, 1: carry into bit 0. The multiplier ties it to 0.
- `sum`, out, W: registered `(a + b + cin) mod 2^W`.
- `cout`, out, 1: registered carry out of bit W−1.
- `out_valid`, out, 1: `sum`/`cout` hold a result from `in_valid` one cycle earlier.

## Operation
- Half-adder cell: `s = x ^ y`, `c = x & y`.
- Full-adder cell: `s = x ^ y ^ ci`, `co = (x & y) | (ci & (x ^ y))`.
- The cells are separate submodules, named `half_adder_cell` and `full_adder_cell`.
- Chain structure:
  - Bit 0 uses a full-adder cell with `ci = cin`.
  - Bits 1..W−1 use full-adder cells, each fed the carry of the bit below.
  - The carry out of bit W−1 is the next-state `cout`.
- When `cin` is tied to 0, bit 0 may be a half-adder cell; results are identical.
- No carry-lookahead and no behavioural `+` in the datapath; the ripple chain is structural.
- Arithmetic is unsigned and wraps modulo 2^W.
  - Overflow is reported only through `cout`; there is no saturation.
  - Biased-exponent underflow/overflow handling belongs to the caller.
- Capture rule on each rising `clk`:
  - `in_valid = 1`: register `sum`, `cout`, and `out_valid = 1`.
  - `in_valid = 0`: `out_valid` goes to 0; `sum` and `cout` hold their previous values.
- X on an input while `in_valid = 0` must not propagate into `sum` or `cout`.

## Timing
- Latency: exactly 1 cycle, from `in_valid` sampled high to `out_valid` high with the corresponding result.
- Throughput: one operation per cycle. Back-to-back `in_valid` gives back-to-back results in order.
- There is no backpressure and no ready signal.
- Reset (`rst_n` low), asynchronous and independent of `clk`: `sum = 0`, `cout = 0`, `out_valid = 0`.
- Reset asserted mid-stream discards the in-flight result.
- After `rst_n` rises, the first capture occurs at the next rising `clk` edge that sees `in_valid = 1`.
- Critical path: W full-adder carry stages plus the register setup time. Adding a second pipeline stage is out of scope.

## Test plan
- Reset: drive `rst_n = 0` with random inputs toggling → `sum = 0`, `cout = 0`, `out_valid = 0` immediately and throughout, with no `clk` edge required.
- Bias add, W=5: `a = 5'b01111`, `b = 5'b00001`, `cin = 0`, `in_valid = 1` → next cycle `sum = 5'b10000`, `cout = 0`, `out_valid = 1`.
- Wrap: `a = 5'b11111`, `b = 5'b00001`, `cin = 0` → `sum = 5'b00000`, `cout = 1`. Then `a = 5'b11111`, `b = 5'b11111`, `cin = 1` → `sum = 5'b11111`, `cout = 1`.
- Two's-complement subtract path: `a = 5'b10100` (20), `b = ~5'b01111 = 5'b10000`, `cin = 1` → `sum = 5'b00101` (5), `cout = 1`.
- Hold behaviour: one valid op (`3 + 4`) followed by `in_valid = 0` with `a`/`b` changed → `sum` stays 7 and `out_valid` drops to 0 after one cycle.
- Exhaustive sweep, W=5: all 2048 combinations of `a`, `b`, `cin` streamed back-to-back → each `{cout, sum}` equals `a + b + cin` exactly one cycle later. Repeat with W=8 over random vectors.
